// File: rtl/cond_sched_if.sv
//==== cond_sched_if : decode/execute bundle of the condition scheduler (rev 1.0) ====
`default_nettype none

interface cond_sched_if;
  logic       id_valid;
  logic       id_ready;
  logic [3:0] id_cond;
  logic       id_setflags;
  logic       id_late;
  logic       id_branch;
  logic [3:0] alu_flags;
  logic       late_valid;
  logic [3:0] late_flags;
  logic       ex_valid;
  logic       ex_exec;
  logic       ex_squash;
  logic       branch_taken;
  logic [3:0] nzcv;
  logic       flag_err;

  modport master (
    output id_valid, id_cond, id_setflags, id_late, id_branch, alu_flags,
           late_valid, late_flags,
    input  id_ready, ex_valid, ex_exec, ex_squash, branch_taken, nzcv, flag_err
  );

  modport slave (
    input  id_valid, id_cond, id_setflags, id_late, id_branch, alu_flags,
           late_valid, late_flags,
    output id_ready, ex_valid, ex_exec, ex_squash, branch_taken, nzcv, flag_err
  );
endinterface

`default_nettype wire

// File: rtl/cond_sched.sv
//==== cond_sched : execute-stage condition evaluation, NZCV ownership, late-flag stall, branch squash (rev 1.0) ====
`default_nettype none

module cond_sched #(
  parameter int FLUSH_DEPTH = 2,
  parameter int TIMEOUT     = 15
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  cond_sched_if.slave bus
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_nzcv;
  logic [2:0] r_squash_cnt;
  logic [7:0] r_wait_cnt;
  logic       r_flag_err;
  logic       r_ex_valid;
  logic       r_ex_exec;
  logic       r_ex_squash;
  logic       r_branch_taken;

  logic w_accept;
  logic w_pass;
  logic w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = r_nzcv;

  always_comb begin
    w_pass = 1'b0;
    case (bus.id_cond)
      4'd0:    w_pass = w_z;
      4'd1:    w_pass = !w_z;
      4'd2:    w_pass = w_c;
      4'd3:    w_pass = !w_c;
      4'd4:    w_pass = w_n;
      4'd5:    w_pass = !w_n;
      4'd6:    w_pass = w_v;
      4'd7:    w_pass = !w_v;
      4'd8:    w_pass = w_c && !w_z;
      4'd9:    w_pass = !w_c || w_z;
      4'd10:   w_pass = (w_n == w_v);
      4'd11:   w_pass = (w_n != w_v);
      4'd12:   w_pass = !w_z && (w_n == w_v);
      4'd13:   w_pass = w_z || (w_n != w_v);
      default: w_pass = 1'b1;
    endcase
  end

  // Ready depends on state alone so decode never sees a valid->ready loop.
  assign bus.id_ready = (r_state == S_RUN);
  assign w_accept     = bus.id_valid && (r_state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_RUN;
      r_nzcv         <= 4'b0000;
      r_squash_cnt   <= 3'd0;
      r_wait_cnt     <= 8'd0;
      r_flag_err     <= 1'b0;
      r_ex_valid     <= 1'b0;
      r_ex_exec      <= 1'b0;
      r_ex_squash    <= 1'b0;
      r_branch_taken <= 1'b0;
    end else begin
      r_ex_valid     <= w_accept;
      r_ex_exec      <= 1'b0;
      r_ex_squash    <= 1'b0;
      r_branch_taken <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            if (r_squash_cnt != 3'd0) begin
              r_ex_squash  <= 1'b1;
              r_squash_cnt <= r_squash_cnt - 3'd1;
            end else if (w_pass) begin
              r_ex_exec <= 1'b1;
              if (bus.id_branch) begin
                r_branch_taken <= 1'b1;
                r_squash_cnt   <= 3'(FLUSH_DEPTH);
              end
              if (bus.id_setflags) begin
                if (bus.id_late) begin
                  r_state    <= S_WAIT;
                  r_wait_cnt <= 8'd0;
                end else begin
                  r_nzcv <= bus.alu_flags;
                end
              end
            end
          end
        end
        S_WAIT: begin
          // Late flags win over a timeout landing in the same cycle.
          if (bus.late_valid) begin
            r_nzcv     <= bus.late_flags;
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt == 8'(TIMEOUT - 1)) begin
            r_flag_err <= 1'b1;
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign bus.nzcv         = r_nzcv;
  assign bus.flag_err     = r_flag_err;
  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_exec      = r_ex_exec;
  assign bus.ex_squash    = r_ex_squash;
  assign bus.branch_taken = r_branch_taken;

endmodule

`default_nettype wire

// File: tb/tb_cond_sched.sv
//==== tb_cond_sched : directed and randomized checks of cond_sched against a flag/squash model (rev 1.0) ====
`default_nettype none

module tb_cond_sched;
  localparam int FLUSH_DEPTH = 2;
  localparam int TIMEOUT     = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cond_sched_if bus ();

  cond_sched #(.FLUSH_DEPTH(FLUSH_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] m_nzcv;
  int         m_squash;
  bit         m_wait;
  int         m_wait_cycles;
  bit         m_err;
  bit exp_valid, exp_exec, exp_squash, exp_bt;

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;        1: return !z;
      2: return cy;       3: return !cy;
      4: return n;        5: return !n;
      6: return v;        7: return !v;
      8: return cy && !z; 9: return !cy || z;
      10: return n == v;  11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_nzcv = 4'b0000; m_squash = 0; m_wait = 0; m_wait_cycles = 0; m_err = 0;
    exp_valid = 0; exp_exec = 0; exp_squash = 0; exp_bt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #7;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drive one cycle of inputs, advance the model by one clock, then sample point.
  task automatic step(input bit v, input logic [3:0] c, input bit sf, input bit late,
                      input bit br, input logic [3:0] alu, input bit lv, input logic [3:0] lf);
    bit acc;
    bus.id_valid = v; bus.id_cond = c; bus.id_setflags = sf; bus.id_late = late;
    bus.id_branch = br; bus.alu_flags = alu; bus.late_valid = lv; bus.late_flags = lf;
    acc = v && !m_wait;
    exp_valid = acc; exp_exec = 0; exp_squash = 0; exp_bt = 0;
    if (m_wait) begin
      m_wait_cycles++;
      if (lv) begin
        m_nzcv = lf; m_wait = 0;
      end else if (m_wait_cycles == TIMEOUT) begin
        m_err = 1; m_wait = 0;
      end
    end else if (acc) begin
      if (m_squash > 0) begin
        exp_squash = 1; m_squash--;
      end else if (cond_ok(c, m_nzcv)) begin
        exp_exec = 1;
        if (br) begin exp_bt = 1; m_squash = FLUSH_DEPTH; end
        if (sf && late) begin m_wait = 1; m_wait_cycles = 0; end
        else if (sf) m_nzcv = alu;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 4'd14, 0, 0, 0, 4'd0, 0, 4'd0);
  endtask

  task automatic test_reset();
    bus.id_valid = 0; bus.id_cond = 0; bus.id_setflags = 0; bus.id_late = 0;
    bus.id_branch = 0; bus.alu_flags = 0; bus.late_valid = 0; bus.late_flags = 0;
    do_reset();
    n_checks++;
    if ({bus.id_ready, bus.nzcv, bus.flag_err, bus.ex_valid, bus.ex_exec, bus.ex_squash, bus.branch_taken}
        !== {1'b1, 4'b0000, 1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b nzcv=%b err=%b ex=%b%b%b bt=%b, expected ready=1 nzcv=0000 err=0 ex=000 bt=0",
               bus.id_ready, bus.nzcv, bus.flag_err, bus.ex_valid, bus.ex_exec, bus.ex_squash, bus.branch_taken);
    end
  endtask

  task automatic test_branch_squash();
    logic [2:0] got;
    logic [2:0] want [3];
    want[0] = 3'b110; want[1] = 3'b110; want[2] = 3'b101;
    step(1, 4'd14, 1, 0, 0, 4'b0100, 0, 4'd0);
    n_checks++;
    if ({bus.ex_exec, bus.nzcv} !== {1'b1, 4'b0100}) begin
      n_fail++; $display("FAIL adds_exec: got exec=%b nzcv=%b, expected exec=1 nzcv=0100", bus.ex_exec, bus.nzcv);
    end
    step(1, 4'd0, 0, 0, 1, 4'b0000, 0, 4'd0);
    n_checks++;
    if ({bus.ex_exec, bus.branch_taken} !== 2'b11) begin
      n_fail++; $display("FAIL beq_taken: got exec=%b bt=%b, expected 1 1", bus.ex_exec, bus.branch_taken);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 4'd14, 0, 0, 0, 4'd0, 0, 4'd0);
      got = {bus.ex_valid, bus.ex_squash, bus.ex_exec};
      n_checks++;
      if (got !== want[i]) begin
        n_fail++; $display("FAIL squash_window[%0d]: got valid/squash/exec=%b, expected %b", i, got, want[i]);
      end
    end
    idle();
    n_checks++;
    if ({bus.ex_valid, bus.branch_taken} !== 2'b00) begin
      n_fail++; $display("FAIL idle_outputs: got valid=%b bt=%b, expected 0 0", bus.ex_valid, bus.branch_taken);
    end
  endtask

  task automatic test_cond_hi_ls_le();
    logic [3:0] flags [2];
    logic [2:0] want [2];
    logic [2:0] got;
    flags[0] = 4'b0010; flags[1] = 4'b0110;
    want[0]  = 3'b100;  want[1]  = 3'b011;
    for (int k = 0; k < 2; k++) begin
      step(1, 4'd14, 1, 0, 0, flags[k], 0, 4'd0);
      step(1, 4'd8, 0, 0, 0, 4'd0, 0, 4'd0);  got[2] = bus.ex_exec;
      step(1, 4'd9, 0, 0, 0, 4'd0, 0, 4'd0);  got[1] = bus.ex_exec;
      step(1, 4'd13, 0, 0, 0, 4'd0, 0, 4'd0); got[0] = bus.ex_exec;
      n_checks++;
      if (got !== want[k]) begin
        n_fail++; $display("FAIL cond_hi_ls_le nzcv=%b: got exec HI/LS/LE=%b, expected %b", flags[k], got, want[k]);
      end
    end
  endtask

  task automatic test_late_flags();
    int stall = 0;
    step(1, 4'd14, 1, 1, 0, 4'b0001, 0, 4'd0);
    for (int i = 1; i <= 10 && !bus.id_ready; i++) begin
      stall++;
      step(0, 4'd14, 0, 0, 0, 4'd0, (i == 3), 4'b1000);
    end
    n_checks++;
    if (stall !== 3 || bus.nzcv !== 4'b1000) begin
      n_fail++; $display("FAIL late_stall: got stall=%0d nzcv=%b, expected stall=3 nzcv=1000", stall, bus.nzcv);
    end
    step(1, 4'd4, 0, 0, 0, 4'd0, 0, 4'd0);
    n_checks++;
    if (bus.ex_exec !== 1'b1) begin
      n_fail++; $display("FAIL late_mi_exec: got exec=%b, expected 1", bus.ex_exec);
    end
  endtask

  task automatic test_timeout();
    int stall;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      step(1, 4'd14, 1, 0, 0, 4'b0011, 0, 4'd0);
      step(1, 4'd14, 1, 1, 0, 4'b1111, 0, 4'd0);
      stall = 0;
      for (int i = 1; i <= 40 && !bus.id_ready; i++) begin
        stall++;
        step(0, 4'd14, 0, 0, 0, 4'd0, (k == 1 && i == TIMEOUT), 4'b1001);
      end
      n_checks++;
      if (k == 0 && {stall[7:0], bus.flag_err, bus.nzcv} !== {8'(TIMEOUT), 1'b1, 4'b0011}) begin
        n_fail++; $display("FAIL timeout: got stall=%0d err=%b nzcv=%b, expected stall=15 err=1 nzcv=0011",
                           stall, bus.flag_err, bus.nzcv);
      end
      if (k == 1 && {stall[7:0], bus.flag_err, bus.nzcv} !== {8'(TIMEOUT), 1'b0, 4'b1001}) begin
        n_fail++; $display("FAIL timeout_edge_late: got stall=%0d err=%b nzcv=%b, expected stall=15 err=0 nzcv=1001",
                           stall, bus.flag_err, bus.nzcv);
      end
      idle(); idle();
      n_checks++;
      if (bus.flag_err !== (k == 0)) begin
        n_fail++; $display("FAIL flag_err_sticky[%0d]: got %b, expected %b", k, bus.flag_err, (k == 0));
      end
    end
  endtask

  task automatic test_squash_no_side_effects();
    step(1, 4'd14, 1, 0, 0, 4'b0100, 0, 4'd0);
    step(1, 4'd14, 0, 0, 1, 4'd0, 0, 4'd0);
    step(1, 4'd1, 1, 0, 0, 4'b1111, 0, 4'd0);
    n_checks++;
    if ({bus.ex_squash, bus.ex_exec, bus.branch_taken, bus.nzcv} !== {3'b100, 4'b0100}) begin
      n_fail++; $display("FAIL squash_ne_setter: got sq/ex/bt=%b%b%b nzcv=%b, expected 100 0100",
                         bus.ex_squash, bus.ex_exec, bus.branch_taken, bus.nzcv);
    end
    step(1, 4'd14, 1, 0, 1, 4'b0001, 0, 4'd0);
    n_checks++;
    if ({bus.ex_squash, bus.ex_exec, bus.branch_taken, bus.nzcv} !== {3'b100, 4'b0100}) begin
      n_fail++; $display("FAIL squash_al_branch: got sq/ex/bt=%b%b%b nzcv=%b, expected 100 0100",
                         bus.ex_squash, bus.ex_exec, bus.branch_taken, bus.nzcv);
    end
    step(1, 4'd0, 1, 0, 0, 4'b0010, 0, 4'd0);
    n_checks++;
    if ({bus.ex_exec, bus.nzcv} !== {1'b1, 4'b0010}) begin
      n_fail++; $display("FAIL post_squash_exec: got exec=%b nzcv=%b, expected 1 0010", bus.ex_exec, bus.nzcv);
    end
  endtask

  task automatic test_reset_mid_wait();
    step(1, 4'd14, 1, 0, 0, 4'b1010, 0, 4'd0);
    step(1, 4'd14, 1, 1, 1, 4'd0, 0, 4'd0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.id_ready, bus.nzcv, bus.ex_valid} !== {1'b1, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid_wait: got ready=%b nzcv=%b valid=%b, expected 1 0000 0",
                         bus.id_ready, bus.nzcv, bus.ex_valid);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 4'd14, 0, 0, 0, 4'd0, 0, 4'd0);
    n_checks++;
    if ({bus.ex_exec, bus.ex_squash} !== 2'b10) begin
      n_fail++; $display("FAIL after_reset_accept: got exec=%b squash=%b, expected 1 0", bus.ex_exec, bus.ex_squash);
    end
  endtask

  task automatic test_random();
    logic [9:0] got, want;
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
      got  = {bus.ex_valid, bus.ex_exec, bus.ex_squash, bus.branch_taken, bus.nzcv, bus.flag_err, bus.id_ready};
      want = {exp_valid, exp_exec, exp_squash, exp_bt, m_nzcv, m_err, !m_wait};
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL random[%0d] {valid,exec,squash,bt,nzcv,err,ready}: got %b, expected %b", i, got, want);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_branch_squash();
    test_cond_hi_ls_le();
    test_late_flags();
    test_timeout();
    do_reset();
    test_squash_no_side_effects();
    test_reset_mid_wait();
    do_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
